// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI transmitter: command handshake in, 8N1 LSB-first serial line out
// Optional feature macro: MIDI_TX_RUNNING_STATUS_EN (omit status byte when it repeats)
module midi_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 31250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [3:0] channel,
  input  logic [6:0] data1,
  input  logic [6:0] data2,
  output logic       tx,
  output logic       busy
);
  localparam int BIT_CLKS = CLK_FREQ / BAUD;
  localparam int CW       = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d, bit_nx;
  logic [1:0]      idx_q, idx_d, last_q, last_d;
  logic [2:0][7:0] msg_q, msg_d;
  logic            tx_q, tx_d, busy_q, busy_d;
  logic            accept, bit_end, skip;
  logic [7:0]      status, cur_byte;

  assign cmd_ready = (state_q == IDLE);
  assign accept    = ce & cmd_valid & cmd_ready;
  assign bit_end   = (cnt_q == CNT_LAST);
  assign bit_nx    = bit_q + 3'd1;
  assign tx        = tx_q;
  assign busy      = busy_q;

  always_comb begin
    case (cmd_type)
      2'b00:   status = {4'h8, channel};
      2'b01:   status = {4'h9, channel};
      default: status = {4'hC, channel};
    endcase
  end

  always_comb begin
    case (idx_q)
      2'd0:    cur_byte = msg_q[0];
      2'd1:    cur_byte = msg_q[1];
      default: cur_byte = msg_q[2];
    endcase
  end

`ifdef MIDI_TX_RUNNING_STATUS_EN
  // 8'h00 can never be a status byte, so it doubles as "no status sent yet".
  logic [7:0] last_status;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_status <= 8'h00;
    end else if (accept && cmd_type != 2'b11) begin
      last_status <= status;
    end
  end

  assign skip = (status == last_status);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    last_d  = last_q;
    msg_d   = msg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    if (ce) begin
      case (state_q)
        IDLE: begin
          // Reserved commands complete the handshake here and are dropped.
          if (accept && cmd_type != 2'b11) begin
            msg_d   = {1'b0, data2, 1'b0, data1, status};
            idx_d   = skip ? 2'd1 : 2'd0;
            last_d  = (cmd_type == 2'b10) ? 2'd1 : 2'd2;
            state_d = START;
            cnt_d   = '0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_d = DATA;
            cnt_d   = '0;
            bit_d   = 3'd0;
            tx_d    = cur_byte[0];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_d = '0;
            if (bit_q == 3'd7) begin
              state_d = STOP;
              tx_d    = 1'b1;
            end else begin
              bit_d = bit_nx;
              tx_d  = cur_byte[bit_nx];
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_d = '0;
            if (idx_q == last_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = START;
              tx_d    = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      msg_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      msg_q   <= msg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule
